// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period measurement block.
package clk_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PH1  = 3'd2,
    ST_PH2  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int          CNT_W_DEF   = 16;
  localparam logic [15:0] TIMEOUT_DEF = 16'hFFFF;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level and produces registered edge/fall pulses,
// suppressed while the synchronizer fills after reset.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic edge_o,
  output logic fall_o
);

  localparam int WARM_CYC = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;
  logic                   fall_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   s_s;
  logic                   warm_done_s;

  assign s_s         = sync_q[SYNC_STAGES-1];
  assign warm_done_s = (warm_q == WARM_W'(WARM_CYC));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      fall_q <= 1'b0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= s_s;
      edge_q <= (s_s ^ prev_q) & warm_done_s;
      fall_q <= prev_q & ~s_s & warm_done_s;
      if (!warm_done_s) begin
        warm_q <= warm_q + WARM_W'(1);
      end
    end
  end

  // prev_q is the level that produced the current edge/fall pulse
  assign level_o = prev_q;
  assign edge_o  = edge_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/clk_period_meas.sv
// Measures high/low phase lengths of a slow asynchronous clock-like signal and
// reports the equivalent clock divider count through a valid/ready handshake.
module clk_period_meas
  import clk_meas_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sig_i,
  output logic             meas_valid_o,
  input  logic             meas_ready_i,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] low_cnt_o,
  output logic [CNT_W-1:0] div_count_o,
  output logic             mismatch_o,
  output logic             timeout_o,
  output logic             busy_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cap_high_q;
  logic [CNT_W-1:0] cap_low_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;
  logic [CNT_W-1:0] div_q;
  logic             valid_q;
  logic             mism_q;
  logic             to_q;

  logic             level_s;
  logic             edge_s;
  logic             fall_s;
  logic             close_high_s;
  logic             close_low_s;
  logic             measuring_s;
  logic             expired_s;
  logic [CNT_W-1:0] fin_high_s;
  logic [CNT_W-1:0] fin_low_s;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .async_i(sig_i),
    .level_o(level_s),
    .edge_o (edge_s),
    .fall_o (fall_s)
  );

  assign close_high_s = fall_s;
  assign close_low_s  = edge_s & level_s;
  assign measuring_s  = (state_q == ST_ARM) | (state_q == ST_PH1) | (state_q == ST_PH2);
  assign expired_s    = measuring_s & ~edge_s & (cnt_q == TIMEOUT);
  assign fin_high_s   = close_high_s ? cnt_q : cap_high_q;
  assign fin_low_s    = close_low_s ? cnt_q : cap_low_q;

  always_comb begin
    cnt_d = cnt_q;
    if (edge_s) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Abort beats timeout, and a same-cycle edge beats timeout via expired_s
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cap_high_q <= '0;
      cap_low_q  <= '0;
      high_q     <= '0;
      low_q      <= '0;
      div_q      <= '0;
      valid_q    <= 1'b0;
      mism_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (measuring_s && !en_i) begin
        state_q <= ST_IDLE;
      end else if (expired_s) begin
        state_q <= ST_DONE;
        high_q  <= '0;
        low_q   <= '0;
        div_q   <= '0;
        mism_q  <= 1'b0;
        to_q    <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (en_i) begin
              state_q <= ST_ARM;
              cnt_q   <= CNT_W'(1);
            end
          end
          ST_ARM: begin
            if (edge_s) begin
              state_q <= ST_PH1;
            end
          end
          ST_PH1: begin
            if (edge_s) begin
              if (close_high_s) begin
                cap_high_q <= cnt_q;
              end else begin
                cap_low_q <= cnt_q;
              end
              state_q <= ST_PH2;
            end
          end
          ST_PH2: begin
            if (edge_s) begin
              high_q  <= fin_high_s;
              low_q   <= fin_low_s;
              div_q   <= fin_high_s - CNT_W'(1);
              mism_q  <= (fin_high_s != fin_low_s);
              to_q    <= 1'b0;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (!valid_q) begin
              valid_q <= 1'b1;
            end else if (meas_ready_i) begin
              valid_q <= 1'b0;
              if (en_i) begin
                state_q <= ST_ARM;
                cnt_q   <= CNT_W'(1);
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign meas_valid_o = valid_q;
  assign high_cnt_o   = high_q;
  assign low_cnt_o    = low_q;
  assign div_count_o  = div_q;
  assign mismatch_o   = mism_q;
  assign timeout_o    = to_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
